// File: rtl/full_add_pkg.sv
// Shared types for the 1-bit full-adder slice.
// Output bundle and operand encoding used by the core and its wrapper.
package full_add_pkg;

  typedef struct packed {
    logic carry;
    logic sum;
  } fa_out_t;

  localparam fa_out_t FA_ZERO = '{carry: 1'b0, sum: 1'b0};

endpackage

// File: rtl/full_add_core.sv
// Combinational full-add equations.
// Sum is a three-way XOR; carry reuses the a^b term for the majority.
module full_add_core
  import full_add_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  logic axb;

  assign axb   = a ^ b;
  assign sum   = axb ^ c;
  // (a&b)|(a&c)|(b&c) folded onto the shared propagate term
  assign carry = (a & b) | (axb & c);

endmodule

// File: rtl/full_add.sv
// 1-bit full adder with an optional output register.
// REG_OUT=1 gives one cycle of latency; REG_OUT=0 is pure logic.
module full_add
  import full_add_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  fa_out_t d;

  full_add_core u_core (
    .a     (a),
    .b     (b),
    .c     (c),
    .sum   (d.sum),
    .carry (d.carry)
  );

  generate
    if (REG_OUT) begin : g_reg
      fa_out_t q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= FA_ZERO;
        end else begin
          q <= d;
        end
      end

      assign sum   = q.sum;
      assign carry = q.carry;
    end else begin : g_comb
      // clock and reset have no role without the register
      logic unused;
      assign unused = clk ^ rst_n;
      assign sum    = d.sum;
      assign carry  = d.carry;
    end
  endgenerate

endmodule

// File: tb/tb_full_add.sv
// Directed bench for full_add, registered and combinational builds.
// Expected values come from the arithmetic sum a+b+c.
module tb_full_add;

  logic clk;
  logic rst_n;
  logic a, b, c;
  logic sum1, carry1;
  logic sum0, carry0;

  int errs;
  int checks;

  full_add #(.REG_OUT(1'b1)) dut_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .sum   (sum1),
    .carry (carry1)
  );

  full_add #(.REG_OUT(1'b0)) dut_comb (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .sum   (sum0),
    .carry (carry0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] fa_exp(input logic [2:0] v);
    return {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

  task automatic chk(
    input string      tag,
    input logic [1:0] got,
    input logic [1:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got {carry,sum}=%b want %b at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] v);
    {a, b, c} = v;
  endtask

  initial begin
    logic [2:0] v;
    logic [1:0] prev;
    errs   = 0;
    checks = 0;
    rst_n  = 1'b0;
    drive(3'b111);

    // reset held across an edge: registered output stays zero
    #12;
    chk("reset_state", {carry1, sum1}, 2'b00);
    rst_n = 1'b1;

    // registered sweep, one new operand set per cycle
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive(v);
      @(posedge clk);
      #1;
      chk($sformatf("sweep_reg_%b", v), {carry1, sum1}, fa_exp(v));
    end

    // output holds between edges after inputs change
    drive(3'b000);
    #3;
    chk("hold_between", {carry1, sum1}, fa_exp(3'b111));

    // combinational sweep, no clock dependence
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive(v);
      #1;
      chk($sformatf("sweep_comb_%b", v), {carry0, sum0}, fa_exp(v));
      #9;
    end

    // async reset between edges
    drive(3'b111);
    @(posedge clk);
    #1;
    chk("pre_reset_111", {carry1, sum1}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_immediate", {carry1, sum1}, 2'b00);
    for (int k = 0; k < 2; k++) begin
      drive(3'(k * 3 + 3));
      @(posedge clk);
      #1;
      chk($sformatf("reset_hold_%0d", k), {carry1, sum1}, 2'b00);
    end

    // release with 101: zero until the next edge, then s0 c1
    drive(3'b101);
    #2;
    rst_n = 1'b1;
    #1;
    chk("release_wait", {carry1, sum1}, 2'b00);
    @(posedge clk);
    #1;
    chk("release_load", {carry1, sum1}, 2'b10);

    // mid-stream reset discards the in-flight 111
    drive(3'b001);
    @(posedge clk);
    #1;
    chk("stream_001", {carry1, sum1}, 2'b01);
    drive(3'b111);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    drive(3'b000);
    #2;
    rst_n = 1'b1;
    #1;
    chk("no_stale", {carry1, sum1}, 2'b00);
    @(posedge clk);
    #1;
    chk("after_flush", {carry1, sum1}, 2'b00);

    // back-to-back toggle 000/111, one-cycle delay
    prev = 2'b00;
    for (int k = 0; k < 6; k++) begin
      v = (k % 2 == 1) ? 3'b000 : 3'b111;
      drive(v);
      #1;
      chk($sformatf("toggle_old_%0d", k), {carry1, sum1}, prev);
      @(posedge clk);
      #1;
      chk($sformatf("toggle_new_%0d", k), {carry1, sum1}, fa_exp(v));
      prev = fa_exp(v);
    end

    // unknown input for one cycle, then recovery
    a = 1'bx;
    b = 1'b0;
    c = 1'b0;
    @(posedge clk);
    #1;
    drive(3'b010);
    @(posedge clk);
    #1;
    chk("x_recover_reg", {carry1, sum1}, 2'b01);
    chk("x_recover_comb", {carry0, sum0}, 2'b01);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
